// File: rtl/if_stage.sv
// Instruction-fetch stage: word-addressed PC register feeding instruction memory, plus the IF/ID register.
// Optional jump pre-decode is enabled by defining IF_JUMP_PREDECODE_EN.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [5:0]  J_OPCODE = 6'b100110
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect_en,
   input  logic [31:0] redirect_target,
   output logic [31:0] imem_adr,
   input  logic [31:0] imem_dout,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc1,
   output logic        if_id_valid,
   output logic        if_id_jtaken
);

   logic [31:0] pc_reg, pc_next, pc_plus1;
   logic [31:0] instr_reg, instr_next;
   logic [31:0] pc1_reg, pc1_next;
   logic        valid_reg, valid_next;
   logic        jtaken_reg, jtaken_next;
   logic        bubble, capture, is_jump;
   logic [31:0] jump_target;

   assign pc_plus1 = pc_reg + 32'd1;
   assign bubble   = redirect_en | flush;
   assign capture  = ~bubble & ~stall;

`ifdef IF_JUMP_PREDECODE_EN
   // Jump target keeps the upper bits of the fall-through PC, like a MIPS-style region jump.
   assign is_jump     = capture & (imem_dout[31:26] == J_OPCODE);
   assign jump_target = {pc_plus1[31:26], imem_dout[25:0]};
`else
   logic unused_jopcode;
   assign unused_jopcode = ^J_OPCODE;
   assign is_jump        = 1'b0;
   assign jump_target    = pc_plus1;
`endif

   always_comb begin
      pc_next     = pc_plus1;
      instr_next  = imem_dout;
      pc1_next    = pc_plus1;
      valid_next  = 1'b1;
      jtaken_next = is_jump;

      // A flush without redirect holds PC so the same address is refetched.
      if (redirect_en)
         pc_next = redirect_target;
      else if (stall || flush)
         pc_next = pc_reg;
      else if (is_jump)
         pc_next = jump_target;

      if (bubble) begin
         instr_next  = 32'h0;
         pc1_next    = 32'h0;
         valid_next  = 1'b0;
         jtaken_next = 1'b0;
      end else if (stall) begin
         instr_next  = instr_reg;
         pc1_next    = pc1_reg;
         valid_next  = valid_reg;
         jtaken_next = jtaken_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_reg     <= RESET_PC;
         instr_reg  <= 32'h0;
         pc1_reg    <= 32'h0;
         valid_reg  <= 1'b0;
         jtaken_reg <= 1'b0;
      end else begin
         pc_reg     <= pc_next;
         instr_reg  <= instr_next;
         pc1_reg    <= pc1_next;
         valid_reg  <= valid_next;
         jtaken_reg <= jtaken_next;
      end
   end

   assign imem_adr     = pc_reg;
   assign if_id_instr  = instr_reg;
   assign if_id_pc1    = pc1_reg;
   assign if_id_valid  = valid_reg;
   assign if_id_jtaken = jtaken_reg;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: driver checks PC/bubbles directly and queues expected IF/ID
// transactions; a negedge monitor pops and compares each new valid IF/ID transaction.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst, stall, flush, redirect_en;
   logic [31:0] redirect_target;
   logic [31:0] imem_adr, imem_dout;
   logic [31:0] if_id_instr, if_id_pc1;
   logic        if_id_valid, if_id_jtaken;
   logic        jump_en = 1'b0;

`ifdef IF_JUMP_PREDECODE_EN
   localparam bit PRE = 1'b1;
`else
   localparam bit PRE = 1'b0;
`endif

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc1;
      logic        jt;
   } txn_t;

   txn_t sb_q[$];
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   if_stage dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .redirect_en(redirect_en), .redirect_target(redirect_target),
      .imem_adr(imem_adr), .imem_dout(imem_dout),
      .if_id_instr(if_id_instr), .if_id_pc1(if_id_pc1),
      .if_id_valid(if_id_valid), .if_id_jtaken(if_id_jtaken)
   );

   function automatic logic [31:0] word_at(input logic [31:0] a, input logic jen);
      if (jen && a == 32'd9) return 32'h9800_0005;
      return {6'b000001, a[25:0]};
   endfunction

   assign imem_dout = word_at(imem_adr, jump_en);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Plain capturing cycle at PC p; expects next PC np.
   task automatic fetch(input logic [31:0] p, input logic [31:0] np, input logic jt);
      stall = 0; flush = 0; redirect_en = 0; rst = 0;
      sb_q.push_back('{instr: word_at(p, jump_en), pc1: p + 32'd1, jt: jt});
      tick();
      chk("imem_adr", imem_adr, np);
   endtask

   // Monitor: a valid IF/ID whose contents changed is a new transaction.
   initial begin : monitor
      logic        prev_valid = 1'b0;
      logic [31:0] prev_instr = 32'h0, prev_pc1 = 32'h0;
      txn_t        e;
      forever begin
         @(negedge clk);
         if (if_id_valid && (!prev_valid || if_id_pc1 != prev_pc1 || if_id_instr != prev_instr)) begin
            if (sb_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_txn: got pc1=%h instr=%h expected none", if_id_pc1, if_id_instr);
            end else begin
               e = sb_q.pop_front();
               $display("[TB] txn pc1=%h instr=%h jtaken=%0b", if_id_pc1, if_id_instr, if_id_jtaken);
               chk("txn_instr", if_id_instr, e.instr);
               chk("txn_pc1", if_id_pc1, e.pc1);
               chk("txn_jtaken", {31'h0, if_id_jtaken}, {31'h0, e.jt});
            end
         end
         prev_valid = if_id_valid;
         prev_instr = if_id_instr;
         prev_pc1   = if_id_pc1;
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin : driver
      rst = 1; stall = 0; flush = 0; redirect_en = 0; redirect_target = 32'h0;
      tick(); tick();
      chk("rst_adr", imem_adr, 32'h0);
      chk("rst_valid", {31'h0, if_id_valid}, 32'h0);
      chk("rst_instr", if_id_instr, 32'h0);
      chk("rst_pc1", if_id_pc1, 32'h0);

      // Sequential fetch from reset
      fetch(0, 1, 0); fetch(1, 2, 0); fetch(2, 3, 0); fetch(3, 4, 0);

      // Stall three cycles at PC=4
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_adr", imem_adr, 32'd4);
         chk("stall_pc1", if_id_pc1, 32'd4);
         chk("stall_valid", {31'h0, if_id_valid}, 32'd1);
      end
      fetch(4, 5, 0); fetch(5, 6, 0);

      // Flush alone at PC=6
      flush = 1;
      tick();
      chk("flush_adr", imem_adr, 32'd6);
      chk("flush_valid", {31'h0, if_id_valid}, 32'd0);
      fetch(6, 7, 0); fetch(7, 8, 0);

      // Redirect with stall at PC=8
      stall = 1; redirect_en = 1; redirect_target = 32'h0000_000A;
      tick();
      chk("redir_adr", imem_adr, 32'd10);
      chk("redir_valid", {31'h0, if_id_valid}, 32'd0);
      fetch(10, 11, 0);
      chk("redir_pc1", if_id_pc1, 32'd11);

      // Jump pre-decode at PC=9
      redirect_en = 1; redirect_target = 32'd9;
      tick();
      chk("j_redir_adr", imem_adr, 32'd9);
      jump_en = 1;
      fetch(9, PRE ? 32'd5 : 32'd10, PRE);
      chk("j_pc1", if_id_pc1, 32'd10);
      chk("j_jtaken", {31'h0, if_id_jtaken}, {31'h0, PRE});
      jump_en = 0;

      // Wrap at 32'hFFFF_FFFF
      redirect_en = 1; redirect_target = 32'hFFFF_FFFF;
      tick();
      chk("wrap_redir_adr", imem_adr, 32'hFFFF_FFFF);
      fetch(32'hFFFF_FFFF, 32'h0, 0);
      chk("wrap_pc1", if_id_pc1, 32'h0);

      // Reset overriding stall/redirect/flush mid-stall at PC=32'hFFFF_FFFF
      redirect_en = 1; redirect_target = 32'hFFFF_FFFF;
      tick();
      redirect_en = 0; stall = 1;
      tick();
      chk("pre_rst_adr", imem_adr, 32'hFFFF_FFFF);
      rst = 1; redirect_en = 1; flush = 1; redirect_target = 32'h0000_1234;
      tick();
      chk("rst2_adr", imem_adr, 32'h0);
      chk("rst2_valid", {31'h0, if_id_valid}, 32'h0);
      chk("rst2_instr", if_id_instr, 32'h0);
      chk("rst2_pc1", if_id_pc1, 32'h0);
      chk("rst2_jtaken", {31'h0, if_id_jtaken}, 32'h0);
      fetch(0, 1, 0); fetch(1, 2, 0);

      @(negedge clk); #1;
      chk("sb_empty", sb_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, word address loaded into PC on reset.
REQ-002 Parameter J_OPCODE, default 6'b100110, opcode of the unconditional jump used by pre-decode.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hold PC and IF/ID register.
REQ-006 flush  input  1  invalidate IF/ID contents.
REQ-007 redirect_en  input  1  load PC from redirect_target (branch/jump resolved downstream).
REQ-008 redirect_target  input  32  word address of redirect.
REQ-009 imem_adr  output  32  instruction-memory word address, equal to PC.
REQ-010 imem_dout  input  32  instruction returned combinationally for imem_adr.
REQ-011 if_id_instr  output  32  registered instruction.
REQ-012 if_id_pc1  output  32  registered PC+1 of that instruction.
REQ-013 if_id_valid  output  1  IF/ID holds a real instruction.
REQ-014 if_id_jtaken  output  1  instruction was a jump already taken by pre-decode.

Function
REQ-015 PC is word-addressed; sequential next PC SHALL be PC+1, modulo 2^32 (32'hFFFF_FFFF wraps to 0).
REQ-016 imem_adr SHALL equal the PC register at all times (zero added latency to memory).
REQ-017 Next-PC priority SHALL be: rst > redirect_en > stall > pre-decode jump > PC+1.
REQ-018 IF/ID update priority SHALL be: rst > (redirect_en or flush) -> bubble > stall -> hold > capture.
REQ-019 Capture SHALL load if_id_instr=imem_dout, if_id_pc1=PC+1, if_id_valid=1, if_id_jtaken per REQ-027/028.
REQ-020 Bubble SHALL load if_id_instr=32'h0, if_id_pc1=32'h0, if_id_valid=0, if_id_jtaken=0.
REQ-021 Stall without redirect/flush SHALL hold PC and all IF/ID outputs unchanged.
REQ-022 flush without redirect_en SHALL hold PC (refetch same address next cycle) and insert bubble.
REQ-023 redirect_en with stall SHALL still load PC=redirect_target and insert bubble.
REQ-024 Fetch-to-IF/ID latency SHALL be one cycle; throughput one instruction per unstalled cycle.
REQ-025 After redirect in cycle N, imem_adr SHALL equal redirect_target in cycle N+1 and its instruction SHALL appear valid in IF/ID in N+2 absent stall/flush.

Reset
REQ-026 On rst=1 at a rising edge: PC=RESET_PC, IF/ID = bubble values; reset SHALL override stall, flush and redirect_en in the same cycle, including mid-stall.

Configuration
REQ-027 With macro IF_JUMP_PREDECODE_EN defined: when capturing and imem_dout[31:26]==J_OPCODE, next PC SHALL be {PC_plus1[31:26], imem_dout[25:0]} and if_id_jtaken=1; downstream SHALL not re-redirect for such instructions.
REQ-028 Without IF_JUMP_PREDECODE_EN: no pre-decode; next PC is PC+1 and if_id_jtaken SHALL be tied to 0.

Verification
REQ-029 rst high 2 cycles, release, no stall, sequential instructions -> imem_adr 0,1,2,3 on successive cycles; if_id_pc1 1,2,3 one cycle later with valid=1.
REQ-030 stall high 3 cycles while PC=4 -> imem_adr stays 4, IF/ID holds PC=3 instruction (pc1=4), resumes at 5 after release.
REQ-031 redirect_en=1, target 32'h0000_000A at PC=8 with stall=1 -> next imem_adr=10, if_id_valid=0 one cycle, then instruction at 10 valid with pc1=11.
REQ-032 flush alone at PC=6 -> if_id_valid=0, imem_adr stays 6 next cycle, then 7.
REQ-033 Macro defined, imem_dout=32'b100110_00000000000000000000000101 at PC=9 -> next imem_adr=5, if_id_jtaken=1, pc1=10; macro undefined -> next imem_adr=10, jtaken=0.
REQ-034 rst asserted during stall and redirect at PC=32'hFFFF_FFFF -> PC=RESET_PC, bubble; separately, unstalled PC=32'hFFFF_FFFF -> next imem_adr=0.
